r2r_window_averager: RTL and testbench

Downstream of the R2R ladder ADC subsystem: takes each raw 8-bit conversion code (ramp or SAR path) and keeps a sliding-window moving average over the last 2^LOG2_N samples in a ring buffer with a running sum. It produces a 12-bit averaged code and a millivolt-scaled value for the display and readout path. It is a drop-in consumer of the subsystem's `raw_data` plus a one-cycle sample strobe.

---
 rtl/r2r_adc_pkg.sv | 25 ++
 rtl/r2r_window_averager_ring_buffer.sv | 64 ++++++
 rtl/r2r_window_averager.sv | 117 +++++++++++
 tb/tb_r2r_window_averager.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/r2r_adc_pkg.sv
// r2r_adc_pkg
//   Shared constants for the R2R ladder ADC subsystem and its downstream
//   consumers (window averager, display/readout scaling).
//   Contents:
//     ADC_FULL_SCALE_MV : full-scale input voltage in millivolts
//     ADC_RAW_WIDTH     : raw conversion code width
//     ADC_OUT_WIDTH     : averaged / scaled output code width
//     AVG_LOG2_N        : log2 of the moving-average window depth
//     avg_shift()       : right shift taking the running sum to the output code
package r2r_adc_pkg;

  localparam int unsigned ADC_FULL_SCALE_MV = 3300;
  localparam int unsigned ADC_RAW_WIDTH     = 8;
  localparam int unsigned ADC_OUT_WIDTH     = 12;
  localparam int unsigned AVG_LOG2_N        = 8;

  // The running sum is in_width+log2_n bits wide; keeping its top out_width
  // bits divides by the window depth and rescales to the output width at once.
  function automatic int unsigned avg_shift(input int unsigned in_width,
                                            input int unsigned log2_n,
                                            input int unsigned out_width);
    return in_width + log2_n - out_width;
  endfunction

endpackage

// File: rtl/r2r_window_averager_ring_buffer.sv
// sample_ring_buffer
//   Circular store of the last 2^LOG2_N accepted samples. On each accepted
//   sample it reads the slot about to be overwritten (the sample leaving the
//   window) and writes the new sample into it in the same cycle.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : synchronous flush of pointer, fill count and old_data
//     accept     : a new sample is taken this cycle (already gated by clear)
//     din        : sample to store
//     old_data   : registered value leaving the window (0 until filled)
//     filled     : high once 2^LOG2_N samples have been accepted
module sample_ring_buffer
  import r2r_adc_pkg::*;
#(
  parameter int unsigned IN_WIDTH = ADC_RAW_WIDTH,
  parameter int unsigned LOG2_N   = AVG_LOG2_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                accept,
  input  logic [IN_WIDTH-1:0] din,
  output logic [IN_WIDTH-1:0] old_data,
  output logic                filled
);

  localparam int unsigned DEPTH = 1 << LOG2_N;

  logic [IN_WIDTH-1:0] mem [DEPTH];
  logic [LOG2_N-1:0]   wr_ptr;
  logic [LOG2_N:0]     fill_cnt;

  // fill_cnt saturates at exactly 2^LOG2_N, so its MSB is the filled flag.
  assign filled = fill_cnt[LOG2_N];

  // The storage array is not reset: stale contents are never observed because
  // old_data is forced to zero until the window has been filled again.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      old_data <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      old_data <= '0;
    end else if (accept) begin
      // Read-before-write of the same slot; the sample that completes the
      // window still sees filled=0 and therefore subtracts nothing.
      old_data <= filled ? mem[wr_ptr] : '0;
      wr_ptr   <= wr_ptr + 1'b1;
      if (!filled) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/r2r_window_averager.sv
// r2r_window_averager
//   Sliding-window moving average of raw R2R ADC codes over the last
//   2^LOG2_N samples, kept as a running sum, plus a millivolt-scaled copy.
//   Pipeline for a strobe in cycle t:
//     edge t+1 : stage A (new/old sample registered, ring buffer updated)
//     edge t+2 : running sum updated, ave_data reflects the sample
//     edge t+3 : scaled_data updated, out_valid pulses
//   Ports:
//     clk          : system clock
//     reset        : asynchronous active-low reset
//     EN           : accept enable (sample_valid ignored when low)
//     clear        : synchronous flush of window, sum, pipeline and outputs
//     sample_valid : one-cycle strobe qualifying raw_data
//     raw_data     : raw ADC code
//     ave_data     : averaged code (OUT_WIDTH bits)
//     scaled_data  : average scaled to millivolts, saturating
//     out_valid    : one-cycle pulse when scaled_data updates
//     filled       : window holds 2^LOG2_N samples since reset/clear
module r2r_window_averager
  import r2r_adc_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = ADC_RAW_WIDTH,
  parameter int unsigned LOG2_N     = AVG_LOG2_N,
  parameter int unsigned OUT_WIDTH  = ADC_OUT_WIDTH,
  parameter int unsigned SCALE_MULT = ADC_FULL_SCALE_MV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EN,
  input  logic                 clear,
  input  logic                 sample_valid,
  input  logic [IN_WIDTH-1:0]  raw_data,
  output logic [OUT_WIDTH-1:0] ave_data,
  output logic [OUT_WIDTH-1:0] scaled_data,
  output logic                 out_valid,
  output logic                 filled
);

  localparam int unsigned SW    = IN_WIDTH + LOG2_N;
  localparam int unsigned SHIFT = avg_shift(IN_WIDTH, LOG2_N, OUT_WIDTH);
  localparam int unsigned MW    = $clog2(SCALE_MULT + 1);
  localparam int unsigned PW    = OUT_WIDTH + MW;

  logic                 accept;
  logic                 a_valid;
  logic                 b_valid;
  logic [IN_WIDTH-1:0]  new_sample;
  logic [IN_WIDTH-1:0]  old_sample;
  logic [SW-1:0]        sum;
  logic [PW-1:0]        product;
  logic [PW-1:0]        scaled_wide;
  logic [OUT_WIDTH-1:0] scaled_next;

  // clear wins over a coincident strobe: that sample is dropped.
  assign accept = sample_valid & EN & ~clear;

  sample_ring_buffer #(
    .IN_WIDTH (IN_WIDTH),
    .LOG2_N   (LOG2_N)
  ) u_ring (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (clear),
    .accept   (accept),
    .din      (raw_data),
    .old_data (old_sample),
    .filled   (filled)
  );

  // Top OUT_WIDTH bits of the sum == sum >> SHIFT (truncating).
  assign ave_data = sum[SHIFT +: OUT_WIDTH];

  always_comb begin
    product     = PW'(ave_data) * PW'(SCALE_MULT);
    scaled_wide = product >> OUT_WIDTH;
    scaled_next = scaled_wide[OUT_WIDTH-1:0];
    if (scaled_wide > PW'((1 << OUT_WIDTH) - 1)) begin
      scaled_next = '1;
    end
  end

  // Stages A (new sample), B (running sum) and C (scaled output). With EN low
  // no new work enters, but anything already in flight still drains through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_valid     <= 1'b0;
      b_valid     <= 1'b0;
      new_sample  <= '0;
      sum         <= '0;
      scaled_data <= '0;
      out_valid   <= 1'b0;
    end else if (clear) begin
      a_valid     <= 1'b0;
      b_valid     <= 1'b0;
      new_sample  <= '0;
      sum         <= '0;
      scaled_data <= '0;
      out_valid   <= 1'b0;
    end else begin
      a_valid   <= accept;
      b_valid   <= a_valid;
      out_valid <= b_valid;
      if (accept) begin
        new_sample <= raw_data;
      end
      // old_sample is always a value previously added to sum, so the
      // subtraction cannot underflow.
      if (a_valid) begin
        sum <= sum + SW'(new_sample) - SW'(old_sample);
      end
      if (b_valid) begin
        scaled_data <= scaled_next;
      end
    end
  end

endmodule

// File: tb/tb_r2r_window_averager.sv
module tb_r2r_window_averager;

  localparam int unsigned N      = 256;
  localparam int unsigned DIV    = 16;    // 2^(8+8-12)
  localparam int unsigned FS_MV  = 3300;
  localparam int unsigned OUTMAX = 4095;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        EN = 1'b0;
  logic        clear = 1'b0;
  logic        sample_valid = 1'b0;
  logic [7:0]  raw_data = '0;
  logic [11:0] ave_data;
  logic [11:0] scaled_data;
  logic        out_valid;
  logic        filled;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  r2r_window_averager dut (
    .clk          (clk),
    .reset        (reset),
    .EN           (EN),
    .clear        (clear),
    .sample_valid (sample_valid),
    .raw_data     (raw_data),
    .ave_data     (ave_data),
    .scaled_data  (scaled_data),
    .out_valid    (out_valid),
    .filled       (filled)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Window = last N accepted samples (fewer before filled, missing count as 0).
  int unsigned win[$];
  int unsigned acc_cnt = 0;
  int unsigned exp_ave = 0, exp_scaled = 0;
  bit          exp_ov = 0, exp_filled = 0;
  // Results still travelling toward the outputs.
  bit          ave_pend_v = 0, sc_pend_v = 0;
  int unsigned ave_pend = 0, sc_pend = 0;

  function automatic int unsigned scale_mv(input int unsigned ave);
    int unsigned v;
    v = (ave * FS_MV) / 4096;
    return (v > OUTMAX) ? OUTMAX : v;
  endfunction

  function automatic int unsigned window_avg();
    int unsigned s = 0;
    foreach (win[i]) s += win[i];
    return s / DIV;
  endfunction

  task automatic model_flush();
    win.delete();
    acc_cnt = 0;
    exp_ave = 0; exp_scaled = 0; exp_ov = 0; exp_filled = 0;
    ave_pend_v = 0; sc_pend_v = 0; ave_pend = 0; sc_pend = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset || clear) begin
      model_flush();
    end else begin
      exp_ov = sc_pend_v;
      if (sc_pend_v) exp_scaled = sc_pend;
      sc_pend_v = ave_pend_v;
      if (ave_pend_v) begin
        exp_ave = ave_pend;
        sc_pend = scale_mv(ave_pend);
      end
      ave_pend_v = sample_valid && EN;
      if (ave_pend_v) begin
        win.push_back(int'(raw_data));
        if (win.size() > N) void'(win.pop_front());
        if (acc_cnt < N) acc_cnt++;
        ave_pend = window_avg();
      end
      exp_filled = (acc_cnt >= N);
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("ave_data", ave_data, exp_ave);
    check("scaled_data", scaled_data, exp_scaled);
    check("out_valid", out_valid, exp_ov);
    check("filled", filled, exp_filled);
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit sv, input bit en, input bit clr, input logic [7:0] d);
    sample_valid = sv; EN = en; clear = clr; raw_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 1, 0, 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with strobes toggling.
    for (int i = 0; i < 8; i++) step(i[0], 1, 0, 8'd77);
    check("rst_ave", ave_data, 0);
    check("rst_ov", out_valid, 0);
    reset = 1'b1;
    idle(2);

    // Single strobe of 128.
    step(1, 1, 0, 8'd128);
    check("single_t1_ave", ave_data, 0);
    idle(1);
    check("single_t2_ave", ave_data, 8);
    check("single_t2_ov", out_valid, 0);
    idle(1);
    check("single_t3_scaled", scaled_data, 6);
    check("single_t3_ov", out_valid, 1);
    check("single_filled", filled, 0);
    idle(1);
    check("single_t4_ov", out_valid, 0);

    // 256 strobes of 128.
    step(0, 1, 1, 8'd0);
    for (int i = 0; i < 255; i++) step(1, 1, 0, 8'd128);
    check("fill255_filled", filled, 0);
    step(1, 1, 0, 8'd128);
    check("fill256_filled", filled, 1);
    idle(3);
    check("fill_ave", ave_data, 2048);
    check("fill_scaled", scaled_data, 1650);

    // 256 x 255 then 128 zeros.
    step(0, 1, 1, 8'd0);
    for (int i = 0; i < 256; i++) step(1, 1, 0, 8'd255);
    idle(3);
    check("full_ave", ave_data, 4080);
    check("full_scaled", scaled_data, 3287);
    for (int i = 0; i < 128; i++) step(1, 1, 0, 8'd0);
    idle(3);
    check("wrap_ave", ave_data, 2040);
    check("wrap_scaled", scaled_data, 1643);

    // EN low: strobes ignored.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 8'd200);
      check("en0_ov", out_valid, 0);
    end
    check("en0_ave", ave_data, 2040);
    check("en0_scaled", scaled_data, 1643);
    check("en0_filled", filled, 1);
    // Re-enable: 200 replaces the oldest 255 -> sum 32585.
    step(1, 1, 0, 8'd200);
    check("reen_t1_ov", out_valid, 0);
    idle(1);
    check("reen_t2_ave", ave_data, 2036);
    check("reen_t2_ov", out_valid, 0);
    idle(1);
    check("reen_t3_scaled", scaled_data, 1640);
    check("reen_t3_ov", out_valid, 1);

    // Clear coincident with a strobe, mid-stream.
    for (int i = 0; i < 300; i++) step(1, 1, 0, 8'($urandom));
    step(1, 1, 1, 8'd99);
    check("clr_ave", ave_data, 0);
    check("clr_scaled", scaled_data, 0);
    check("clr_filled", filled, 0);
    check("clr_ov", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'd0);
      check("clr_drain_ov", out_valid, 0);
    end

    // Randomised traffic, per-cycle checked against the model.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 299) == 0, 8'($urandom));

    // Reset mid-pipeline.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'd250);
    reset = 1'b0;
    #2;
    check("midrst_ave", ave_data, 0);
    check("midrst_filled", filled, 0);
    step(1, 1, 0, 8'd1);
    reset = 1'b1;
    idle(4);
    check("midrst_ov", out_valid, 0);
    step(1, 1, 0, 8'd240);
    idle(1);
    check("post_rst_ave", ave_data, 15);
    idle(1);
    check("post_rst_scaled", scaled_data, 12);
    check("post_rst_ov", out_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
